// File: rtl/cdiv_seq.sv
// Sequential complex divider q = a / b: one multiply cycle, then two bit-serial
// restoring dividers (real and imaginary) that share the divisor den = |b|^2.
module cdiv_seq #(
    parameter int AWIDTH = 4,
    parameter int BWIDTH = 5,
    parameter int QWIDTH = 9,
    parameter int FRAC   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [AWIDTH-1:0] ar,
    input  logic signed [AWIDTH-1:0] ai,
    input  logic signed [BWIDTH-1:0] br,
    input  logic signed [BWIDTH-1:0] bi,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [QWIDTH-1:0] qr,
    output logic signed [QWIDTH-1:0] qi,
    output logic                     dz,
    output logic                     ovf
);

    localparam int NW = AWIDTH + BWIDTH + 1;                 // numerator width
    localparam int DW = 2 * BWIDTH;                          // denominator width
    localparam int N  = NW + FRAC;                           // quotient bits
    localparam int RW = DW + 1;                              // partial remainder width
    localparam int CW = $clog2(N + 1);
    localparam int LW = ((N > QWIDTH) ? N : QWIDTH) + 1;     // saturation compare width

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    typedef struct packed {
        logic          q;
        logic [RW-1:0] rem;
    } step_t;

    typedef struct packed {
        logic [QWIDTH-1:0] q;
        logic              ovf;
    } sat_t;

    // One restoring step: shift in a dividend bit, keep the difference if it did not borrow.
    function automatic step_t div_step(input logic [RW-1:0] rem, input logic bit_in,
                                       input logic [DW-1:0] den);
        logic [RW-1:0] shifted;
        logic [RW:0]   trial;
        step_t         s;
        shifted = {rem[RW-2:0], bit_in};
        trial   = {1'b0, shifted} - {2'b00, den};
        s.q     = ~trial[RW];
        s.rem   = trial[RW] ? shifted : trial[RW-1:0];
        return s;
    endfunction

    function automatic sat_t saturate(input logic [N-1:0] mag, input logic neg);
        logic [LW-1:0] mag_w;
        logic [LW-1:0] pos_lim;
        logic [LW-1:0] neg_lim;
        sat_t          s;
        mag_w   = LW'(mag);
        neg_lim = LW'(1) << (QWIDTH - 1);
        pos_lim = neg_lim - LW'(1);
        s.ovf   = 1'b0;
        if (neg) begin
            if (mag_w > neg_lim) begin
                s.q   = {1'b1, {(QWIDTH-1){1'b0}}};
                s.ovf = 1'b1;
            end else begin
                s.q = QWIDTH'(LW'(0) - mag_w);
            end
        end else begin
            if (mag_w > pos_lim) begin
                s.q   = {1'b0, {(QWIDTH-1){1'b1}}};
                s.ovf = 1'b1;
            end else begin
                s.q = QWIDTH'(mag_w);
            end
        end
        return s;
    endfunction

    state_t                    state_q, state_d;
    logic signed [AWIDTH-1:0]  ar_q, ar_d, ai_q, ai_d;
    logic signed [BWIDTH-1:0]  br_q, br_d, bi_q, bi_d;
    logic [DW-1:0]             den_q, den_d;
    logic                      nr_neg_q, nr_neg_d, ni_neg_q, ni_neg_d;
    logic [N-1:0]              nr_sh_q, nr_sh_d, ni_sh_q, ni_sh_d;
    logic [RW-1:0]             rr_q, rr_d, ri_q, ri_d;
    logic [N-1:0]              qr_acc_q, qr_acc_d, qi_acc_q, qi_acc_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [QWIDTH-1:0]         qr_q, qr_d, qi_q, qi_d;
    logic                      dz_q, dz_d, ovf_q, ovf_d;

    logic signed [NW-1:0]      nr_c, ni_c;
    logic [NW-1:0]             nr_mag, ni_mag;
    logic signed [DW-1:0]      br_sq, bi_sq;
    logic [DW-1:0]             den_c;
    step_t                     step_r, step_i;
    logic [N-1:0]              qr_next, qi_next;
    sat_t                      sat_r, sat_i;

    // NOTE: combinational logic uses blocking (=) assignments; only the clocked
    // block below uses non-blocking (<=), so every flop samples settled _d values.
    always_comb begin
        nr_c   = NW'(ar_q) * NW'(br_q) + NW'(ai_q) * NW'(bi_q);
        ni_c   = NW'(ai_q) * NW'(br_q) - NW'(ar_q) * NW'(bi_q);
        nr_mag = nr_c[NW-1] ? (NW'(0) - nr_c) : nr_c;
        ni_mag = ni_c[NW-1] ? (NW'(0) - ni_c) : ni_c;
        br_sq  = DW'(br_q) * DW'(br_q);
        bi_sq  = DW'(bi_q) * DW'(bi_q);
        den_c  = br_sq + bi_sq;

        step_r  = div_step(rr_q, nr_sh_q[N-1], den_q);
        step_i  = div_step(ri_q, ni_sh_q[N-1], den_q);
        qr_next = {qr_acc_q[N-2:0], step_r.q};
        qi_next = {qi_acc_q[N-2:0], step_i.q};
        sat_r   = saturate(qr_next, nr_neg_q);
        sat_i   = saturate(qi_next, ni_neg_q);
    end

    // NOTE: every _d gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        ai_d     = ai_q;
        br_d     = br_q;
        bi_d     = bi_q;
        den_d    = den_q;
        nr_neg_d = nr_neg_q;
        ni_neg_d = ni_neg_q;
        nr_sh_d  = nr_sh_q;
        ni_sh_d  = ni_sh_q;
        rr_d     = rr_q;
        ri_d     = ri_q;
        qr_acc_d = qr_acc_q;
        qi_acc_d = qi_acc_q;
        cnt_d    = cnt_q;
        qr_d     = qr_q;
        qi_d     = qi_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ar_d    = ar;
                    ai_d    = ai;
                    br_d    = br;
                    bi_d    = bi;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                den_d    = den_c;
                nr_neg_d = nr_c[NW-1];
                ni_neg_d = ni_c[NW-1];
                nr_sh_d  = N'(nr_mag) << FRAC;
                ni_sh_d  = N'(ni_mag) << FRAC;
                rr_d     = '0;
                ri_d     = '0;
                qr_acc_d = '0;
                qi_acc_d = '0;
                cnt_d    = CW'(N);
                state_d  = S_DIV;
            end
            S_DIV: begin
                // The zero-divisor test uses the registered den, so it resolves on the first DIV cycle.
                if (den_q == '0) begin
                    qr_d    = '0;
                    qi_d    = '0;
                    dz_d    = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    nr_sh_d  = nr_sh_q << 1;
                    ni_sh_d  = ni_sh_q << 1;
                    rr_d     = step_r.rem;
                    ri_d     = step_i.rem;
                    qr_acc_d = qr_next;
                    qi_acc_d = qi_next;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        qr_d    = sat_r.q;
                        qi_d    = sat_i.q;
                        dz_d    = 1'b0;
                        ovf_d   = sat_r.ovf | sat_i.ovf;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            den_q    <= '0;
            nr_neg_q <= 1'b0;
            ni_neg_q <= 1'b0;
            nr_sh_q  <= '0;
            ni_sh_q  <= '0;
            rr_q     <= '0;
            ri_q     <= '0;
            qr_acc_q <= '0;
            qi_acc_q <= '0;
            cnt_q    <= '0;
            qr_q     <= '0;
            qi_q     <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            ai_q     <= ai_d;
            br_q     <= br_d;
            bi_q     <= bi_d;
            den_q    <= den_d;
            nr_neg_q <= nr_neg_d;
            ni_neg_q <= ni_neg_d;
            nr_sh_q  <= nr_sh_d;
            ni_sh_q  <= ni_sh_d;
            rr_q     <= rr_d;
            ri_q     <= ri_d;
            qr_acc_q <= qr_acc_d;
            qi_acc_q <= qi_acc_d;
            cnt_q    <= cnt_d;
            qr_q     <= qr_d;
            qi_q     <= qi_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign qr        = qr_q;
    assign qi        = qi_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule
